// File: rtl/c17_pkg.sv
// Shared definitions for the C17 preimage search: widths, field bit
// positions and the scan controller state encoding.
package c17_pkg;

   localparam int C17_NUM_IN  = 5;
   localparam int C17_NUM_OUT = 2;
   localparam int C17_NUM_VEC = 32;

   // Bit positions of the C17 primary inputs inside a candidate / resp_vector
   localparam int VEC_P1GAT = 0;
   localparam int VEC_P2GAT = 1;
   localparam int VEC_P3GAT = 2;
   localparam int VEC_P6GAT = 3;
   localparam int VEC_P7GAT = 4;

   // Bit positions of the C17 primary outputs inside req_target / eval result
   localparam int TGT_P22GAT = 1;
   localparam int TGT_P23GAT = 0;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

endpackage

// File: rtl/c17_eval.sv
// Golden combinational C17 function: one input vector in, {p_22gat, p_23gat} out.
module c17_eval
   import c17_pkg::*;
(
   input  logic [C17_NUM_IN-1:0]  vec,
   output logic [C17_NUM_OUT-1:0] outs
);

   logic n8;
   logic n9;

   assign n8 = vec[VEC_P3GAT] & vec[VEC_P6GAT];
   assign n9 = vec[VEC_P2GAT] & ~n8;

   assign outs[TGT_P22GAT] = n9 | (vec[VEC_P1GAT] & vec[VEC_P3GAT]);
   assign outs[TGT_P23GAT] = n9 | (vec[VEC_P7GAT] & ~n8);

endmodule

// File: rtl/c17_preimage_search.sv
// Exhaustive inverse of C17: scans all 32 input vectors in ascending order,
// streams every vector whose outputs equal the requested pair, then emits a
// summary beat carrying the number of matches.
module c17_preimage_search
   import c17_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   abort,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [C17_NUM_OUT-1:0] req_target,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [C17_NUM_IN-1:0]  resp_vector,
   output logic                   resp_done,
   output logic [5:0]             resp_count,
   output logic                   busy
);

   localparam logic [C17_NUM_IN-1:0] LAST_CAND = C17_NUM_IN'(C17_NUM_VEC - 1);

   state_t                 state;
   logic [C17_NUM_OUT-1:0] target;
   logic [C17_NUM_IN-1:0]  cand;
   logic [5:0]             count;
   logic [C17_NUM_OUT-1:0] cand_out;
   logic                   slot_free;
   logic                   hit;

   c17_eval u_eval (
      .vec  (cand),
      .outs (cand_out)
   );

   // The output register can take a new beat when empty or drained this cycle
   assign slot_free = !resp_valid || resp_ready;
   assign hit       = (cand_out == target);

   // Held low while reset is applied so no request is acknowledged during reset
   assign req_ready = rst_n && (state == IDLE);
   assign busy      = (state != IDLE);

   // Scan controller, candidate/match counters and the single-entry output slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         target      <= '0;
         cand        <= '0;
         count       <= '0;
         resp_valid  <= 1'b0;
         resp_vector <= '0;
         resp_done   <= 1'b0;
         resp_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  target <= req_target;
                  cand   <= '0;
                  count  <= '0;
                  state  <= SCAN;
               end
            end

            SCAN: begin
               if (abort) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_done  <= 1'b0;
                  resp_count <= '0;
               end else if (slot_free) begin
                  if (hit) begin
                     resp_valid  <= 1'b1;
                     resp_vector <= cand;
                     resp_done   <= 1'b0;
                     resp_count  <= '0;
                     count       <= count + 6'd1;
                  end else begin
                     resp_valid <= 1'b0;
                  end
                  if (cand == LAST_CAND) begin
                     state <= DONE;
                  end else begin
                     cand <= cand + 5'd1;
                  end
               end
            end

            DONE: begin
               if (abort) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_done  <= 1'b0;
                  resp_count <= '0;
               end else if (resp_valid && resp_done) begin
                  if (resp_ready) begin
                     resp_valid <= 1'b0;
                     resp_done  <= 1'b0;
                     resp_count <= '0;
                     state      <= IDLE;
                  end
               end else if (slot_free) begin
                  resp_valid  <= 1'b1;
                  resp_done   <= 1'b1;
                  resp_vector <= '0;
                  resp_count  <= count;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_c17_preimage_search.sv
// Scoreboard bench for c17_preimage_search: requests push the hand-derived
// expected beats into a queue, a monitor pops and compares accepted beats.
module tb_c17_preimage_search;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       abort = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_target = 2'b00;
   logic       resp_valid;
   logic       resp_ready = 1'b1;
   logic [4:0] resp_vector;
   logic       resp_done;
   logic [5:0] resp_count;
   logic       busy;

   logic [4:0] gold_vec = '0;
   logic [1:0] gold_out;

   typedef struct {
      logic       done;
      logic [4:0] vec;
      logic [5:0] cnt;
      int         when;
   } beat_t;

   // Hand-derived C17 truth table, {p_22gat, p_23gat} per input vector 0..31
   localparam logic [1:0] GOLD [32] = '{
      2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b11,
      2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10,
      2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11,
      2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
   localparam logic [5:0] EXP_COUNT [4] = '{6'd9, 6'd5, 6'd5, 6'd13};

   beat_t sb_q[$];
   beat_t mon_b;
   int    tests = 0;
   int    fails = 0;
   int    summaries = 0;
   int    data_beats = 0;
   int    cyc = 0;
   bit    ready_random = 1'b0;
   bit    prev_stall = 1'b0;

   c17_preimage_search dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .abort       (abort),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_target  (req_target),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_vector (resp_vector),
      .resp_done   (resp_done),
      .resp_count  (resp_count),
      .busy        (busy)
   );

   c17_eval u_gold (
      .vec  (gold_vec),
      .outs (gold_out)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle index, stable between edges
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_scan(input logic [1:0] t, input int k, input bit timed);
      beat_t b;
      for (int i = 0; i < 32; i++) begin
         if (GOLD[i] == t) begin
            b.done = 1'b0;
            b.vec  = 5'(i);
            b.cnt  = 6'd0;
            b.when = timed ? (k + 2 + i) : -1;
            sb_q.push_back(b);
         end
      end
      b.done = 1'b1;
      b.vec  = 5'd0;
      b.cnt  = EXP_COUNT[t];
      b.when = timed ? (k + 34) : -1;
      sb_q.push_back(b);
   endtask

   // Offers a request (called just after a rising edge) and returns the handshake cycle
   task automatic applyStimulus(input logic [1:0] t, input bit timed, output int k);
      int guard = 0;
      k = -1;
      req_valid  = 1'b1;
      req_target = t;
      while (k < 0 && guard < 100) begin
         @(negedge clk);
         if (req_ready) begin
            k = cyc;
            push_scan(t, k, timed);
         end
         guard++;
         tick();
      end
      req_valid = 1'b0;
      if (k < 0) check("req_accept_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic wait_summaries(input int n, input string name);
      int guard = 0;
      while (summaries < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check(name, summaries, n);
      check({name, "_drained"}, sb_q.size(), 0);
      tick();
   endtask

   // Consumer-side ready: held high, or randomly toggled for backpressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         resp_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compares every presented beat with the queue head, pops on acceptance
   always @(negedge clk) begin
      if (!rst_n || abort) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("valid_held_while_stalled", 32'(resp_valid), 32'd1);
         if (resp_valid && sb_q.size() == 0) begin
            check("unexpected_beat", 32'(resp_valid), 32'd0);
         end else if (resp_valid) begin
            mon_b = sb_q[0];
            check("beat_done", 32'(resp_done), 32'(mon_b.done));
            check("beat_vector", 32'(resp_vector), 32'(mon_b.vec));
            check("beat_count", 32'(resp_count), 32'(mon_b.cnt));
            if (resp_ready) begin
               if (mon_b.when >= 0) check("beat_cycle", cyc, mon_b.when);
               void'(sb_q.pop_front());
               if (mon_b.done) summaries++;
               else data_beats++;
            end
         end
         prev_stall = resp_valid && !resp_ready;
      end
   end

   // Directed test sequence
   initial begin
      int k;
      int k2;
      int base;
      int guard;

      for (int i = 0; i < 32; i++) begin
         gold_vec = 5'(i);
         #1;
         check("golden_table", 32'(gold_out), 32'(GOLD[i]));
      end

      // Reset values
      repeat (2) tick();
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_req_ready", 32'(req_ready), 32'd1);
      check("post_reset_vector", 32'(resp_vector), 32'd0);
      check("post_reset_done", 32'(resp_done), 32'd0);
      check("post_reset_count", 32'(resp_count), 32'd0);
      tick();

      // Per-target scans with ready held high and exact beat timing
      applyStimulus(2'b10, 1'b1, k);
      wait_summaries(1, "scan_10");
      applyStimulus(2'b00, 1'b1, k);
      wait_summaries(2, "scan_00");
      applyStimulus(2'b01, 1'b1, k);
      wait_summaries(3, "scan_01");
      applyStimulus(2'b11, 1'b1, k);
      wait_summaries(4, "scan_11");

      // Request offered in the cycle the summary beat is accepted
      applyStimulus(2'b10, 1'b1, k);
      guard = 0;
      while (cyc < k + 33 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      tick();
      req_valid  = 1'b1;
      req_target = 2'b00;
      @(negedge clk);
      check("summary_visible", 32'(resp_valid && resp_done), 32'd1);
      check("req_ready_during_summary_accept", 32'(req_ready), 32'd0);
      tick();
      @(negedge clk);
      check("req_ready_after_summary", 32'(req_ready), 32'd1);
      k2 = cyc;
      check("req_ready_return_cycle", k2, k + 35);
      push_scan(2'b00, k2, 1'b1);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      check("busy_after_back_to_back", 32'(busy), 32'd1);
      wait_summaries(6, "back_to_back");

      // Backpressure
      ready_random = 1'b1;
      applyStimulus(2'b11, 1'b0, k);
      wait_summaries(7, "backpressure_11");
      ready_random = 1'b0;
      tick();

      // Abort after three beats
      base = data_beats;
      applyStimulus(2'b11, 1'b1, k);
      guard = 0;
      while (data_beats < base + 3 && guard < 200) begin
         tick();
         guard++;
      end
      abort = 1'b1;
      sb_q.delete();
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      tick();
      applyStimulus(2'b00, 1'b1, k);
      wait_summaries(8, "after_abort_00");

      // Reset in the middle of a scan
      applyStimulus(2'b00, 1'b1, k);
      guard = 0;
      while (cyc < k + 10 && guard < 200) begin
         tick();
         guard++;
      end
      rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      check("midscan_reset_req_ready", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("midscan_reset_valid", 32'(resp_valid), 32'd0);
      check("midscan_reset_vector", 32'(resp_vector), 32'd0);
      check("midscan_reset_done", 32'(resp_done), 32'd0);
      check("midscan_reset_count", 32'(resp_count), 32'd0);
      check("midscan_reset_busy", 32'(busy), 32'd0);
      check("midscan_reset_req_ready_after", 32'(req_ready), 32'd1);
      tick();
      applyStimulus(2'b00, 1'b1, k);
      wait_summaries(9, "after_reset_00");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so a stuck design still reaches the summary line
   initial begin
      #400000;
      fails++;
      $display("[TB] FAIL watchdog: simulation did not complete, got cycle %0d, expected completion", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/c17_preimage_search.md
# c17_preimage_search

Sequential inverse of the C17 benchmark function. The block accepts a requested output pair {p_22gat, p_23gat} and exhaustively scans all 32 input vectors in ascending order. It streams every input vector that produces the requested pair, then closes the stream with a summary beat carrying the match count. It serves as a reference responder in the benchmark verification flow, checking synthesized or FCN-mapped C17 netlists against the golden truth table.

## Interface
- No parameters; widths fixed by C17: 5 inputs, 2 outputs, 32 vectors.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- abort  in  1  synchronous scan cancel, ignored in IDLE.
- req_valid  in  1  request offered.
- req_ready  out  1  high only in IDLE.
- req_target  in  2  bit1 = wanted p_22gat, bit0 = wanted p_23gat.
- resp_valid  out  1  response beat pending.
- resp_ready  in  1  consumer accepts beat.
- resp_vector  out  5  matching input: bit0 p_1gat, bit1 p_2gat, bit2 p_3gat, bit3 p_6gat, bit4 p_7gat.
- resp_done  out  1  1 = summary beat; resp_vector is 0.
- resp_count  out  6  number of matches (0..32), valid on summary beat, 0 otherwise.
- busy  out  1  state != IDLE.

## Operation
- Golden function, with v = candidate, n8 = v[2] & v[3] and n9 = v[1] & ~n8:
  - p_22gat = n9 | (v[0] & v[2])
  - p_23gat = n9 | (v[4] & ~n8)
- States:
  - IDLE: req_ready = 1. A handshake latches req_target, clears cand and count, and moves to SCAN.
  - SCAN: evaluates one candidate per cycle when the output slot is free, i.e. empty or being accepted that cycle.
    - On a match, loads {vector = cand, done = 0} and increments count.
    - After cand 31 is evaluated, moves to DONE.
    - The candidate counter stalls while the slot is occupied and not accepted.
  - DONE: loads the summary beat {done = 1, count} when the slot is free. Returns to IDLE in the cycle the summary beat is accepted.
- Output slot: a single register. While resp_valid is high, all resp_* fields stay stable until resp_ready.
- abort in SCAN or DONE: next state is IDLE, resp_valid clears, and any pending beat is dropped with no summary beat. abort in the same cycle as a request handshake is ignored.
- Counters: cand is 5 bits and does not wrap past 31 (the transition to DONE is taken instead). count is 6 bits, so 32 matches is representable.
- A request offered while the summary beat is being accepted is not taken, because req_ready is still low that cycle. It is accepted the following cycle at the earliest.
- Reset (rst_n = 0, any state, including mid-scan): state IDLE, resp_valid 0, resp_vector 0, resp_done 0, resp_count 0, busy 0, req_ready 0 during reset and 1 from the first cycle after.

## Timing
- Request handshake in cycle k: busy rises in cycle k+1, and candidate i is evaluated in cycle k+1+i when there are no stalls.
- A match on candidate i is visible on resp_* in cycle k+2+i.
- With resp_ready held high, the summary beat is valid in cycle k+34, and req_ready returns high in cycle k+35.
- Each cycle of resp_ready low while a beat is pending delays everything downstream by exactly one cycle.
- Throughput: one candidate per cycle, one response beat per cycle.

## Structure
- Package c17_pkg holds:
  - state enum {IDLE, SCAN, DONE}
  - constants C17_NUM_IN = 5, C17_NUM_OUT = 2, C17_NUM_VEC = 32
  - the bit-mapping constants for the resp_vector and req_target fields
- Sub-module c17_eval: purely combinational, 5-bit vector in, 2-bit {p_22gat, p_23gat} out. The bench reuses it as a golden model.
- Top level: FSM, cand and count counters, single-entry output register.

## Test plan
- target 2'b10, resp_ready held high:
  - vectors 5, 13, 15, 29, 31 at cycles k+7, k+15, k+17, k+31, k+33
  - summary beat at k+34 with count = 5
- Per-target counts:
  - 2'b00: count 9, first vector 0
  - 2'b01: count 5
  - 2'b11: count 13
  - total across the four requests = 32
- Backpressure: target 2'b11 with resp_ready randomly toggled.
  - The same 13 vectors arrive in ascending order.
  - Fields stay stable while stalled.
  - No beat is lost or duplicated.
- abort asserted mid-scan (after 3 beats of target 2'b11):
  - next cycle: resp_valid 0, busy 0, req_ready 1, no summary beat
  - a new request for 2'b00 then yields count 9
- rst_n low for one cycle in cycle k+10 of a scan:
  - all outputs take reset values
  - the next request restarts the scan from vector 0
- Request offered in the same cycle the summary beat is accepted:
  - not accepted that cycle
  - accepted the following cycle, with busy high one cycle later
